// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the writeback stage: load funct3 encodings,
// architectural register indices and the default stack/global pointers.
package wb_regfile_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_SP   = 5'd2;
   localparam logic [4:0] REG_GP   = 5'd3;

   localparam logic [31:0] DEF_SP_INIT = 32'h0000_7FFC;
   localparam logic [31:0] DEF_GP_INIT = 32'h0000_1800;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte or halfword out of an aligned memory word and
// sign- or zero-extends it according to the load funct3. Pure combinational,
// so the IO read path can reuse it unchanged.
module load_extend
   import wb_regfile_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] word,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Halfwords only look at offset[1]; a misaligned low bit is ignored.
   always_comb begin
      byte_sel = word[{offset, 3'b000} +: 8];
      half_sel = offset[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   result = {{16{half_sel[15]}}, half_sel};
         F3_LBU:  result = {24'h000000, byte_sel};
         F3_LHU:  result = {16'h0000, half_sel};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and integer register file. Chooses the writeback value,
// commits it to x1..x31, serves two bypassed decode read ports and an
// unbypassed debug port, and tracks retired instructions plus the last
// committed write for the board display.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int          XLEN    = 32,
   parameter logic [31:0] SP_INIT = DEF_SP_INIT,
   parameter logic [31:0] GP_INIT = DEF_GP_INIT
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            WB_valid,
   input  logic            WB_RegWrite,
   input  logic            WB_MemtoReg,
   input  logic            WB_Link,
   input  logic [2:0]      WB_funct3,
   input  logic [4:0]      WB_rd_addr,
   input  logic [XLEN-1:0] WB_ALUResult,
   input  logic [XLEN-1:0] WB_MemData,
   input  logic [XLEN-1:0] WB_pc4_i,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      dbg_addr,
   output logic [XLEN-1:0] dbg_data,
   output logic            wb_we,
   output logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] instret,
   output logic [4:0]      last_rd,
   output logic [XLEN-1:0] last_data
);

   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] regs_q [32];
   logic [XLEN-1:0] regs_d [32];
   logic [XLEN-1:0] instret_q, instret_d;
   logic [4:0]      last_rd_q, last_rd_d;
   logic [XLEN-1:0] last_data_q, last_data_d;

   load_extend u_load_extend (
      .funct3 (WB_funct3),
      .offset (WB_ALUResult[1:0]),
      .word   (WB_MemData),
      .result (load_data)
   );

   // Writeback source select and commit enable; x0 writes never commit.
   always_comb begin
      if (WB_Link) begin
         wb_data = WB_pc4_i;
      end else if (WB_MemtoReg) begin
         wb_data = load_data;
      end else begin
         wb_data = WB_ALUResult;
      end
      wb_we = WB_valid & WB_RegWrite & (WB_rd_addr != REG_ZERO);
   end

   // Next state of the register array, retire counter and write monitor.
   always_comb begin
      regs_d      = regs_q;
      last_rd_d   = last_rd_q;
      last_data_d = last_data_q;
      instret_d   = instret_q + XLEN'(WB_valid);
      if (wb_we) begin
         regs_d[WB_rd_addr] = wb_data;
         last_rd_d          = WB_rd_addr;
         last_data_d        = wb_data;
      end
   end

   // State registers; reset wins over any write presented in the same cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 32; i++) begin
            if (5'(i) == REG_SP) begin
               regs_q[i] <= SP_INIT;
            end else if (5'(i) == REG_GP) begin
               regs_q[i] <= GP_INIT;
            end else begin
               regs_q[i] <= '0;
            end
         end
         instret_q   <= '0;
         last_rd_q   <= '0;
         last_data_q <= '0;
      end else begin
         regs_q      <= regs_d;
         instret_q   <= instret_d;
         last_rd_q   <= last_rd_d;
         last_data_q <= last_data_d;
      end
   end

   // Decode read ports: x0 is always zero, otherwise forward the value being
   // written this cycle so decode never sees a stale register.
   always_comb begin
      if (rs1_addr == REG_ZERO) begin
         rs1_data = '0;
      end else if (wb_we && (rs1_addr == WB_rd_addr)) begin
         rs1_data = wb_data;
      end else begin
         rs1_data = regs_q[rs1_addr];
      end
      if (rs2_addr == REG_ZERO) begin
         rs2_data = '0;
      end else if (wb_we && (rs2_addr == WB_rd_addr)) begin
         rs2_data = wb_data;
      end else begin
         rs2_data = regs_q[rs2_addr];
      end
   end

   assign dbg_data  = regs_q[dbg_addr];
   assign instret   = instret_q;
   assign last_rd   = last_rd_q;
   assign last_data = last_data_q;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline interface.
- Takes the registered writeback bundle and extracts and sign/zero-extends load data by funct3 and byte offset.
- Selects the writeback source and commits it to a 32x32 integer register file (x0 hardwired to zero).
- Serves two bypassed read ports to decode, plus a debug read port, a retire counter and a last-write monitor for the board display.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- SP_INIT, 32'h0000_7FFC, reset value of x2 (sp).
- GP_INIT, 32'h0000_1800, reset value of x3 (gp).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- WB_valid  in  1  bundle holds a real instruction (0 = bubble).
- WB_RegWrite  in  1  instruction writes rd.
- WB_MemtoReg  in  1  writeback source is load data.
- WB_Link  in  1  writeback source is WB_pc4_i (jal/jalr); overrides MemtoReg.
- WB_funct3  in  3  load width/sign.
- WB_rd_addr  in  5  destination register.
- WB_ALUResult  in  32  ALU result; bits [1:0] are the load byte offset.
- WB_MemData  in  32  aligned word returned by memory/IO.
- WB_pc4_i  in  32  pc+4 of the instruction.
- rs1_addr, rs2_addr  in  5  decode read addresses.
- rs1_data, rs2_data  out  32  decode read data.
- dbg_addr  in  5  debug read address.
- dbg_data  out  32  debug read data (no bypass).
- wb_we  out  1  write committed this cycle (combinational).
- wb_data  out  32  value being written (combinational).
- instret  out  32  retired-instruction count.
- last_rd  out  5  rd of the most recent committed write.
- last_data  out  32  data of the most recent committed write.

Behaviour:
- Reset (async, rstn=0):
  - All registers cleared to 0, except x2=SP_INIT and x3=GP_INIT.
  - instret=0, last_rd=0, last_data=0.
  - Read ports reflect these values combinationally.
  - Reset asserted mid-write: the write is lost; the reset values win.
- Load extract: b = WB_ALUResult[1:0], byte = MemData[8b+7:8b], half = MemData[16*b[1]+15:16*b[1]]; b[0] is ignored for halfwords.
  - 000 lb: sign-extend byte.
  - 001 lh: sign-extend half.
  - 010 lw: full word.
  - 100 lbu: zero-extend byte.
  - 101 lhu: zero-extend half.
  - 011/110/111: full word.
- Source select: wb_data = WB_Link ? WB_pc4_i : WB_MemtoReg ? load_data : WB_ALUResult.
- Commit:
  - wb_we = WB_valid & WB_RegWrite & (WB_rd_addr != 0).
  - When wb_we=1, regs[rd] <= wb_data at the rising edge.
  - Writes to x0 are discarded; x0 always reads 0.
- Read ports are combinational with write-through bypass.
  - If wb_we and rsN_addr == WB_rd_addr, rsN_data = wb_data; otherwise rsN_data = regs[rsN_addr].
  - rsN_addr=0 returns 0 even if rd=0 is presented with RegWrite=1.
  - Both ports may hit the same address simultaneously.
- dbg_data = regs[dbg_addr] with no bypass; it shows the value after the edge.
- instret increments by 1 every cycle WB_valid=1, regardless of RegWrite (stores and branches retire too). It wraps 32'hFFFF_FFFF -> 0 with no flag.
- last_rd/last_data load rd/wb_data on every committed write and hold otherwise. Writes to x0 do not update them.
- Latency: written value visible on the rs ports in the same cycle (bypass) and from the register array the cycle after.
- No handshake, no stall input: the bundle is consumed every cycle and bubbles are marked by WB_valid=0.

Decomposition:
- Shared package / defs header:
  - funct3 load encodings: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - Register indices: REG_ZERO, REG_SP, REG_GP.
  - SP_INIT/GP_INIT defaults.
- One natural sub-module: load_extend (combinational funct3 + offset + word -> 32-bit result), reusable by the IO path.
- Register array, bypass, counter and monitor stay in wb_regfile.

Test Plan:
- Reset, then read rs1=2, rs2=3, dbg=5 -> 32'h0000_7FFC, 32'h0000_1800, 0; instret=0.
- Load extension: MemData=32'h8899_AABB, MemtoReg=1, rd=5, RegWrite=1, valid=1, cycled across cases -> x5 receives:
  - lb, offset 2 -> 32'hFFFF_FF99.
  - lbu, offset 2 -> 32'h0000_0099.
  - lh, offset 3 -> 32'hFFFF_8899.
  - lhu, offset 0 -> 32'h0000_AABB.
  - lw -> 32'h8899_AABB.
- Bypass: ALUResult=32'h1234_5678, rd=7, rs1=rs2=7 in the same cycle -> both ports read 32'h1234_5678 before the edge; dbg_addr=7 shows it only after the edge.
- x0 and bubbles:
  - rd=0, RegWrite=1, ALUResult=32'hDEAD_BEEF, rs1=0 -> rs1_data=0, wb_we=0, last_rd unchanged.
  - WB_valid=0, rd=9 -> x9 unchanged, instret unchanged.
- Link priority: Link=1, MemtoReg=1, pc4=32'h0000_0104, rd=1 -> x1=32'h0000_0104; last_rd=1, last_data=32'h0000_0104; instret +1.
- Wrap and async reset:
  - Force instret to 32'hFFFF_FFFF, one valid cycle -> 0.
  - Then assert rstn low mid-cycle during a write to x4 -> x4=0 immediately; the write is not applied after release.
